cvp14: RTL and testbench



---
 rtl/cvp14.sv | 222 ++++++++++++++++++++++
 tb/tb_cvp14.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvp14.sv
// cvp14: multi-cycle 16-bit vector processor (8 scalar regs, 8 x 16-element vector regs) on a shared DRAM bus.
// Latency: FETCH + DECODE + EXEC (1 / 2 / 16 / 17 cycles by opcode); bus outputs decode combinationally from state.
// Backpressure: none; the DRAM answers a read on the next edge and absorbs a write at the edge where WR=1.
//
// Ports:
//   Clk1     - clock (rising edge)          Reset   - synchronous, active-high
//   Clk2     - pin-compatibility only       DataIn  - DRAM read data (valid one edge after RD)
//   Addr     - DRAM word address            RD / WR - read request / write strobe (never both)
//   DataOut  - DRAM write data (0 if !WR)   V       - overflow of last VADD/VDOT/SMUL
module cvp14 (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic        Clk2,
    input  logic [15:0] DataIn,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] DataOut,
    output logic        V
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SST  = 4'h3;
    localparam logic [3:0] OP_VLD  = 4'h4;
    localparam logic [3:0] OP_VST  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_SLD  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Clk2 exists only for pin compatibility with the original part.
    logic unused_clk2;
    assign unused_clk2 = Clk2;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;      // overflow seen so far within the current vector op
    logic        vflag_q, vflag_d;
    logic [15:0] s_q [8];
    logic [15:0] s_d [8];
    logic [15:0] v_q [8][16];
    logic [15:0] v_d [8][16];

    // Instruction fields
    logic [3:0]  op;
    logic [2:0]  rd_idx, ra, rb;
    logic [5:0]  off6;
    logic [7:0]  imm8;
    logic [11:0] off12;
    assign op     = ir_q[15:12];
    assign rd_idx = ir_q[11:9];
    assign ra     = ir_q[8:6];
    assign rb     = ir_q[5:3];
    assign off6   = ir_q[5:0];
    assign imm8   = ir_q[7:0];
    assign off12  = ir_q[11:0];

    logic [3:0]  elem;
    logic [3:0]  elem_m1;
    logic [15:0] base, mem_addr;
    assign elem     = cnt_q[3:0];
    // VLD writes the element requested on the previous cycle; cnt=16 wraps to 15.
    assign elem_m1  = cnt_q[3:0] - 4'd1;
    assign base     = s_q[ra] + {10'b0, off6};
    assign mem_addr = base + {11'b0, cnt_q};

    // Element datapath: operands come from the pre-instruction register values,
    // so a destination equal to a source still sees old element i at step i.
    logic [15:0]        ea, eb, mul_b, sum, prod;
    logic signed [31:0] prod_full;
    logic               add_ovf, mul_ovf, dot_ovf, first;
    logic [15:0]        acc_in, acc_next;
    logic               ovf_in;

    assign ea        = v_q[ra][elem];
    assign eb        = v_q[rb][elem];
    assign mul_b     = (op == OP_SMUL) ? s_q[rb] : eb;
    assign sum       = ea + eb;
    assign add_ovf   = (ea[15] == eb[15]) && (sum[15] != ea[15]);
    assign prod_full = $signed(ea) * $signed(mul_b);
    assign prod      = prod_full[15:0];
    // Product fits in signed 16 only if bits 31..15 are all copies of the sign.
    assign mul_ovf   = (prod_full[31:15] != {17{prod_full[15]}});
    assign first     = (cnt_q == 5'd0);
    assign acc_in    = first ? 16'd0 : acc_q;
    assign ovf_in    = first ? 1'b0 : ovf_q;
    assign acc_next  = acc_in + prod;
    assign dot_ovf   = (acc_in[15] == prod[15]) && (acc_next[15] != acc_in[15]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        vflag_d = vflag_q;
        s_d     = s_q;
        v_d     = v_q;
        RD      = 1'b0;
        WR      = 1'b0;
        Addr    = pc_q;
        DataOut = 16'd0;

        case (state_q)
            ST_FETCH: begin
                RD      = 1'b1;
                Addr    = pc_q;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = DataIn;
                pc_d    = pc_q + 16'd1;
                cnt_d   = 5'd0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                cnt_d   = cnt_q + 5'd1;
                case (op)
                    OP_VADD: begin
                        v_d[rd_idx][elem] = sum;
                        ovf_d = ovf_in | add_ovf;
                        if (cnt_q == 5'd15) vflag_d = ovf_in | add_ovf;
                        else                state_d = ST_EXEC;
                    end
                    OP_VDOT: begin
                        acc_d = acc_next;
                        ovf_d = ovf_in | mul_ovf | dot_ovf;
                        if (cnt_q == 5'd15) begin
                            s_d[rd_idx] = acc_next;
                            vflag_d     = ovf_in | mul_ovf | dot_ovf;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_SMUL: begin
                        v_d[rd_idx][elem] = prod;
                        ovf_d = ovf_in | mul_ovf;
                        if (cnt_q == 5'd15) vflag_d = ovf_in | mul_ovf;
                        else                state_d = ST_EXEC;
                    end
                    OP_SST: begin
                        WR      = 1'b1;
                        Addr    = base;
                        DataOut = s_q[rd_idx];
                    end
                    OP_VLD: begin
                        if (cnt_q != 5'd16) begin
                            RD      = 1'b1;
                            Addr    = mem_addr;
                            state_d = ST_EXEC;
                        end
                        if (!first) v_d[rd_idx][elem_m1] = DataIn;
                    end
                    OP_VST: begin
                        WR      = 1'b1;
                        Addr    = mem_addr;
                        DataOut = v_q[rd_idx][elem];
                        if (cnt_q != 5'd15) state_d = ST_EXEC;
                    end
                    OP_SLL: s_d[rd_idx] = {s_q[rd_idx][15:8], imm8};
                    OP_SLH: s_d[rd_idx] = {imm8, s_q[rd_idx][7:0]};
                    // PC already points past the J; target is relative to the J itself.
                    OP_J:   pc_d = pc_q - 16'd1 + {{4{off12[11]}}, off12};
                    OP_SLD: begin
                        if (first) begin
                            RD      = 1'b1;
                            Addr    = base;
                            state_d = ST_EXEC;
                        end else begin
                            s_d[rd_idx] = DataIn;
                        end
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            default: ;  // ST_HALT: bus idle until Reset
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            pc_q    <= 16'd0;
            ir_q    <= 16'd0;
            cnt_q   <= 5'd0;
            acc_q   <= 16'd0;
            ovf_q   <= 1'b0;
            vflag_q <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                s_q[r] <= 16'd0;
                for (int e = 0; e < 16; e++) v_q[r][e] <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            vflag_q <= vflag_d;
            s_q     <= s_d;
            v_q     <= v_d;
        end
    end

    assign V = vflag_q;

endmodule

// File: tb/tb_cvp14.sv
// tb_cvp14: directed programs for cvp14 with a DRAM model; bus writes/reads checked by a scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_cvp14;

    logic        Clk1 = 1'b0;
    logic        Clk2;
    logic        Reset;
    logic [15:0] DataIn;
    logic [15:0] Addr;
    logic        RD, WR;
    logic [15:0] DataOut;
    logic        V;

    logic [15:0] Memory [65536];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        bit          cont;   // must land on the cycle right after the previous write
    } wr_t;

    wr_t         wr_q [$];
    logic [15:0] rd_q [$];
    bit          rd_en = 0;
    bit          rd_strict = 0;
    int          cyc = 0;
    int          last_wr = -10;
    wr_t         w;
    logic [15:0] ea;

    always #5 Clk1 = ~Clk1;
    assign Clk2 = ~Clk1;

    cvp14 dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .Clk2    (Clk2),
        .DataIn  (DataIn),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .DataOut (DataOut),
        .V       (V)
    );

    // DRAM: read data appears on the edge after the request; writes land on the WR edge.
    always @(posedge Clk1) begin
        if (RD) DataIn <= Memory[Addr];
        if (WR) Memory[Addr] <= DataOut;
    end

    // Bus monitor / scoreboard
    always @(negedge Clk1) begin
        cyc++;
        if (!Reset) begin
            checks++;
            if (RD && WR) begin
                errors++;
                $display("FAIL rd_wr_excl got RD=%0b WR=%0b want not both", RD, WR);
            end
            if (!WR) begin
                checks++;
                if (DataOut !== 16'h0) begin
                    errors++;
                    $display("FAIL dataout_idle got %h want 0000", DataOut);
                end
            end else begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got addr %h data %h want no write", Addr, DataOut);
                end else begin
                    w = wr_q.pop_front();
                    if (Addr !== w.a || DataOut !== w.d || (w.cont && cyc != last_wr + 1)) begin
                        errors++;
                        $display("FAIL wr_txn got addr %h data %h gap %0d want addr %h data %h contiguous %0b",
                                 Addr, DataOut, cyc - last_wr, w.a, w.d, w.cont);
                    end
                end
                last_wr = cyc;
            end
            if (RD && rd_en) begin
                if (rd_q.size() != 0) begin
                    checks++;
                    ea = rd_q.pop_front();
                    if (Addr !== ea) begin
                        errors++;
                        $display("FAIL rd_addr got %h want %h", Addr, ea);
                    end
                end else if (rd_strict) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected got addr %h want no read", Addr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] r3(input logic [3:0] op, input logic [2:0] d, a, b);
        return {op, d, a, b, 3'b000};
    endfunction
    function automatic logic [15:0] ro(input logic [3:0] op, input logic [2:0] d, a, input logic [5:0] off);
        return {op, d, a, off};
    endfunction
    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] d, input logic [7:0] imm);
        return {op, d, 1'b0, imm};
    endfunction

    localparam logic [15:0] HALT = 16'hF000;
    localparam logic [15:0] NOP  = 16'h9000;

    // Put the core in reset and wipe memory; V0 source data at 0x20 is i.
    task automatic hold_reset();
        Reset = 1'b1;
        @(posedge Clk1);
        #2;
        for (int i = 0; i < 65536; i++) Memory[i] <= 16'h0;
        #1;
        for (int i = 0; i < 16; i++) Memory[16'h20 + i] <= 16'(i);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge Clk1);
        #2 Reset = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (dut.state_q !== 2'd3 && n < 3000) begin
            @(posedge Clk1);
            #1;
            n++;
        end
        chk({name, "_halted"}, {31'b0, dut.state_q === 2'd3}, 32'd1);
        repeat (4) begin
            @(posedge Clk1);
            #1;
            chk({name, "_idle"}, {30'b0, RD, WR}, 32'd0);
        end
        chk({name, "_wr_drain"}, wr_q.size(), 32'd0);
        chk({name, "_rd_drain"}, rd_q.size(), 32'd0);
    endtask

    task automatic push_p1_reads();
        rd_q.push_back(16'h0000);
        rd_q.push_back(16'h0001);
        for (int i = 0; i < 16; i++) rd_q.push_back(16'h0020 + 16'(i));
        rd_q.push_back(16'h0002);
    endtask

    task automatic load_p1();
        Memory[0] <= ri(4'h6, 3'd1, 8'h20);
        Memory[1] <= ro(4'h4, 3'd0, 3'd1, 6'd0);
        Memory[2] <= HALT;
    endtask

    initial begin
        int n;
        logic [15:0] exp;
        Reset = 1'b1;

        // ---- P1: SLL + VLD + HALT, with reset values and full read sequence
        hold_reset();
        load_p1();
        repeat (2) @(posedge Clk1);
        #1;
        chk("rst_pc", dut.pc_q, 32'h0);
        chk("rst_rd", RD, 32'h1);
        chk("rst_addr", Addr, 32'h0);
        chk("rst_wr", WR, 32'h0);
        chk("rst_dout", DataOut, 32'h0);
        chk("rst_v", V, 32'h0);
        chk("rst_s3", dut.s_q[3], 32'h0);
        chk("rst_v7", dut.v_q[7][15], 32'h0);
        push_p1_reads();
        rd_en = 1; rd_strict = 1;
        #1 Reset = 1'b0;
        run_to_halt("p1");
        chk("p1_s1", dut.s_q[1], 32'h20);
        for (int i = 0; i < 16; i++) chk("p1_v0", dut.v_q[0][i], 32'(i));
        rd_en = 0; rd_strict = 0;

        // ---- P2: VADD with signed overflow in element 15
        hold_reset();
        Memory[0] <= ri(4'h6, 3'd1, 8'h20);
        Memory[1] <= ro(4'h4, 3'd0, 3'd1, 6'd0);
        Memory[2] <= ri(4'h6, 3'd1, 8'h40);
        Memory[3] <= ro(4'h4, 3'd1, 3'd1, 6'd0);
        Memory[4] <= r3(4'h0, 3'd2, 3'd0, 3'd1);
        Memory[5] <= HALT;
        for (int i = 0; i < 15; i++) Memory[16'h40 + i] <= 16'h0100;
        Memory[16'h4F] <= 16'h7FFF;
        release_reset();
        run_to_halt("p2");
        chk("p2_v2_15", dut.v_q[2][15], 32'h800E);
        chk("p2_v2_0", dut.v_q[2][0], 32'h0100);
        chk("p2_v2_3", dut.v_q[2][3], 32'h0103);
        chk("p2_vflag", V, 32'h1);

        // ---- P3: same, then a non-overflowing VADD clears V
        hold_reset();
        Memory[0] <= ri(4'h6, 3'd1, 8'h20);
        Memory[1] <= ro(4'h4, 3'd0, 3'd1, 6'd0);
        Memory[2] <= ri(4'h6, 3'd1, 8'h40);
        Memory[3] <= ro(4'h4, 3'd1, 3'd1, 6'd0);
        Memory[4] <= r3(4'h0, 3'd2, 3'd0, 3'd1);
        Memory[5] <= r3(4'h0, 3'd4, 3'd0, 3'd0);
        Memory[6] <= HALT;
        for (int i = 0; i < 15; i++) Memory[16'h40 + i] <= 16'h0100;
        Memory[16'h4F] <= 16'h7FFF;
        release_reset();
        run_to_halt("p3");
        chk("p3_v2_15", dut.v_q[2][15], 32'h800E);
        for (int i = 0; i < 16; i += 5) chk("p3_v4", dut.v_q[4][i], 32'(2 * i));
        chk("p3_vflag", V, 32'h0);

        // ---- P4: VDOT, SMUL by S7=2, VADD with destination == sources
        hold_reset();
        Memory[0] <= ri(4'h6, 3'd1, 8'h20);
        Memory[1] <= ro(4'h4, 3'd0, 3'd1, 6'd0);
        Memory[2] <= r3(4'h1, 3'd0, 3'd0, 3'd0);
        Memory[3] <= ri(4'h6, 3'd7, 8'h02);
        Memory[4] <= r3(4'h2, 3'd3, 3'd0, 3'd7);
        Memory[5] <= r3(4'h0, 3'd0, 3'd0, 3'd0);
        Memory[6] <= HALT;
        release_reset();
        run_to_halt("p4");
        chk("p4_vdot_s0", dut.s_q[0], 32'h04D8);
        for (int i = 0; i < 16; i++) chk("p4_smul_v3", dut.v_q[3][i], 32'(2 * i));
        for (int i = 0; i < 16; i += 3) chk("p4_self_v0", dut.v_q[0][i], 32'(2 * i));
        chk("p4_vflag", V, 32'h0);

        // ---- P5: SMUL overflow (i * 0x1000 exceeds 0x7FFF from i=8)
        hold_reset();
        Memory[0] <= ri(4'h6, 3'd1, 8'h20);
        Memory[1] <= ro(4'h4, 3'd0, 3'd1, 6'd0);
        Memory[2] <= ri(4'h7, 3'd6, 8'h10);
        Memory[3] <= r3(4'h2, 3'd5, 3'd0, 3'd6);
        Memory[4] <= HALT;
        release_reset();
        run_to_halt("p5");
        chk("p5_v5_7", dut.v_q[5][7], 32'h7000);
        chk("p5_v5_8", dut.v_q[5][8], 32'h8000);
        chk("p5_v5_15", dut.v_q[5][15], 32'hF000);
        chk("p5_vflag", V, 32'h1);

        // ---- P6: jump to 0x100, VST at 0xFFF8 wraps into 0x0000..0x0007
        hold_reset();
        Memory[0] <= {4'h8, 12'h100};
        Memory[16'h100] <= ri(4'h6, 3'd1, 8'h20);
        Memory[16'h101] <= ro(4'h4, 3'd0, 3'd1, 6'd0);
        Memory[16'h102] <= ri(4'h7, 3'd2, 8'hFF);
        Memory[16'h103] <= ri(4'h6, 3'd2, 8'hF8);
        Memory[16'h104] <= ro(4'h5, 3'd0, 3'd2, 6'd0);
        Memory[16'h105] <= HALT;
        for (int i = 0; i < 16; i++) wr_q.push_back('{a: 16'hFFF8 + 16'(i), d: 16'(i), cont: (i != 0)});
        release_reset();
        run_to_halt("p6");
        chk("p6_mem_fff8", Memory[16'hFFF8], 32'h0);
        chk("p6_mem_ffff", Memory[16'hFFFF], 32'h7);
        chk("p6_mem_0000", Memory[16'h0000], 32'h8);
        chk("p6_mem_0007", Memory[16'h0007], 32'hF);

        // ---- P7: J with off12=0xFFF at address 5 loops back to 4
        hold_reset();
        for (int i = 0; i < 5; i++) Memory[i] <= NOP;
        Memory[5] <= {4'h8, 12'hFFF};
        for (int i = 0; i < 6; i++) rd_q.push_back(16'(i));
        rd_q.push_back(16'h4); rd_q.push_back(16'h5); rd_q.push_back(16'h4);
        rd_en = 1; rd_strict = 0;
        release_reset();
        repeat (40) @(posedge Clk1);
        #1;
        chk("p7_jump_reads", rd_q.size(), 32'd0);
        rd_en = 0;

        // ---- P8: SST / SLD round trip through 0x100
        hold_reset();
        Memory[0] <= ri(4'h7, 3'd3, 8'hAB);
        Memory[1] <= ri(4'h6, 3'd3, 8'hCD);
        Memory[2] <= ri(4'h6, 3'd4, 8'hE0);
        Memory[3] <= ro(4'h3, 3'd3, 3'd4, 6'h20);
        Memory[4] <= ro(4'hA, 3'd5, 3'd4, 6'h20);
        Memory[5] <= HALT;
        wr_q.push_back('{a: 16'h0100, d: 16'hABCD, cont: 1'b0});
        release_reset();
        run_to_halt("p8");
        chk("p8_sld_s5", dut.s_q[5], 32'hABCD);
        chk("p8_mem_100", Memory[16'h100], 32'hABCD);

        // ---- P9: reset during VLD cycle 7, then re-run from address 0
        hold_reset();
        load_p1();
        release_reset();
        n = 0;
        while (!(dut.state_q === 2'd2 && dut.ir_q[15:12] === 4'h4 && dut.cnt_q === 5'd7) && n < 200) begin
            @(posedge Clk1);
            #1;
            n++;
        end
        chk("p9_reached_vld7", {31'b0, n < 200}, 32'd1);
        Reset = 1'b1;
        @(posedge Clk1);
        #1;
        chk("p9_pc", dut.pc_q, 32'h0);
        chk("p9_s1", dut.s_q[1], 32'h0);
        chk("p9_v0_3", dut.v_q[0][3], 32'h0);
        chk("p9_rd", RD, 32'h1);
        chk("p9_addr", Addr, 32'h0);
        push_p1_reads();
        rd_en = 1; rd_strict = 1;
        Reset = 1'b0;
        run_to_halt("p9");
        for (int i = 0; i < 16; i++) begin
            exp = 16'(i);
            chk("p9_v0", dut.v_q[0][i], {16'b0, exp});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
